// File: rtl/bsr_meta_encode.sv
// BSR metadata encoder: turns a row-ordered stream of nonzero block coordinates
// into row_ptr/col_idx arrays in memory. Optional ordering checks: META_ENC_ORDER_CHECK_EN.
module bsr_meta_encode #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [31:0]           cfg_row_base,
    input  logic [31:0]           cfg_col_base,
    input  logic [15:0]           cfg_num_rows,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [15:0]           in_row,
    input  logic [15:0]           in_col,
    input  logic                  in_last,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           nnz_count
);

    localparam logic [31:0] STRIDE = 32'(DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        IDLE,
        ROWPTR,
        ACCEPT,
        COLWR,
        FLUSH,
        DONE
    } state_t;

    state_t state, state_d;

    logic [31:0] row_base;
    logic [31:0] col_base;
    logic [15:0] num_rows;
    // One bit wider than in_row so the flush pass can step past row 65535.
    logic [16:0] cur_row;
    logic [31:0] nnz;
    logic [15:0] col_q;
    logic        last_q;

    logic        row_hit;
    logic        row_ahead;
    logic        flush_more;
    logic        bad_entry;
    logic        start_acc;
    logic        hs;
    logic        capture;
    logic        advance_row;
    logic        col_done;
    logic        row_step;
    logic [31:0] row_addr;
    logic [31:0] col_addr;

    assign row_hit    = ({1'b0, in_row} == cur_row);
    assign row_ahead  = ({1'b0, in_row} > cur_row);
    assign flush_more = (cur_row <= {1'b0, num_rows});

`ifdef META_ENC_ORDER_CHECK_EN
    logic [15:0] prev_col;
    logic        prev_vld;
    logic        err_q;

    assign bad_entry = ({1'b0, in_row} < cur_row)
                     || (in_row >= num_rows)
                     || (row_hit && prev_vld && (in_col <= prev_col));
    // Offending entries are consumed so the stream cannot stall on them.
    assign in_ready  = (state == ACCEPT) && (row_hit || bad_entry);
    assign err       = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q    <= 1'b0;
            prev_vld <= 1'b0;
            prev_col <= '0;
        end else if (start_acc) begin
            err_q    <= 1'b0;
            prev_vld <= 1'b0;
        end else begin
            if (hs && bad_entry) err_q <= 1'b1;
            if (row_step)        prev_vld <= 1'b0;
            if (capture) begin
                prev_vld <= 1'b1;
                prev_col <= in_col;
            end
        end
    end
`else
    assign bad_entry = 1'b0;
    // Entries behind the current row are folded into the current row.
    assign in_ready  = (state == ACCEPT) && !row_ahead;
    assign err       = 1'b0;
`endif

    assign start_acc   = (state == IDLE) && start;
    assign hs          = (state == ACCEPT) && in_valid && in_ready;
    assign capture     = hs && !bad_entry;
    assign advance_row = (state == ACCEPT) && in_valid && !in_ready;
    assign col_done    = (state == COLWR) && mem_ready;
    assign row_step    = advance_row
                       || (hs && bad_entry)
                       || (col_done && last_q)
                       || ((state == FLUSH) && mem_ready && flush_more);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:   if (start) state_d = ROWPTR;
            ROWPTR: if (mem_ready) state_d = (num_rows == '0) ? DONE : ACCEPT;
            ACCEPT: begin
                if (in_valid) begin
                    if (!in_ready)      state_d = ROWPTR;
                    else if (bad_entry) state_d = FLUSH;
                    else                state_d = COLWR;
                end
            end
            COLWR:  if (mem_ready) state_d = last_q ? FLUSH : ACCEPT;
            FLUSH: begin
                if (!flush_more || (mem_ready && (cur_row == {1'b0, num_rows})))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_base <= '0;
            col_base <= '0;
            num_rows <= '0;
            cur_row  <= '0;
            nnz      <= '0;
            col_q    <= '0;
            last_q   <= 1'b0;
        end else if (start_acc) begin
            row_base <= cfg_row_base;
            col_base <= cfg_col_base;
            num_rows <= cfg_num_rows;
            cur_row  <= '0;
            nnz      <= '0;
            last_q   <= 1'b0;
        end else begin
            if (row_step) cur_row <= cur_row + 17'd1;
            if (col_done) nnz <= nnz + 32'd1;
            if (capture) begin
                col_q  <= in_col;
                last_q <= in_last;
            end
        end
    end

    assign row_addr = row_base + 32'(cur_row) * STRIDE;
    assign col_addr = col_base + nnz * STRIDE;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            ROWPTR: begin
                mem_we    = 1'b1;
                mem_addr  = row_addr;
                mem_wdata = DATA_WIDTH'(nnz);
            end
            COLWR: begin
                mem_we    = 1'b1;
                mem_addr  = col_addr;
                mem_wdata = DATA_WIDTH'(col_q);
            end
            FLUSH: begin
                if (flush_more) begin
                    mem_we    = 1'b1;
                    mem_addr  = row_addr;
                    mem_wdata = DATA_WIDTH'(nnz);
                end
            end
            default: ;
        endcase
    end

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign nnz_count = nnz;

endmodule

// File: tb/tb_bsr_meta_encode.sv
// Directed self-checking bench for bsr_meta_encode (DATA_WIDTH=32).
module tb_bsr_meta_encode;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [31:0]   cfg_row_base;
    logic [31:0]   cfg_col_base;
    logic [15:0]   cfg_num_rows;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_row;
    logic [15:0]   in_col;
    logic          in_last;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          busy;
    logic          done;
    logic          err;
    logic [31:0]   nnz_count;

    bsr_meta_encode #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_row_base (cfg_row_base),
        .cfg_col_base (cfg_col_base),
        .cfg_num_rows (cfg_num_rows),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_row       (in_row),
        .in_col       (in_col),
        .in_last      (in_last),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_ready    (mem_ready),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .nnz_count    (nnz_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory-side responder and write log, all sampled on the falling edge.
    int            stall_n = 0;
    int            wait_cnt = 0;
    bit            held = 0;
    logic [31:0]   held_addr;
    logic [DW-1:0] held_data;
    int            stable_viol = 0;
    int            done_cnt = 0;
    logic [31:0]   wq_addr[$];
    logic [31:0]   wq_data[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            wait_cnt  = 0;
            held      = 0;
            mem_ready = 1'b1;
        end else begin
            mem_ready = (wait_cnt >= stall_n);
            if (held && (!mem_we || mem_addr !== held_addr || mem_wdata !== held_data))
                stable_viol++;
            held = 0;
            if (mem_we) begin
                if (mem_ready) begin
                    wq_addr.push_back(mem_addr);
                    wq_data.push_back(mem_wdata);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                    held      = 1;
                    held_addr = mem_addr;
                    held_data = mem_wdata;
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic start_job(input logic [31:0] rb, input logic [31:0] cb, input logic [15:0] nr);
        cfg_row_base = rb;
        cfg_col_base = cb;
        cfg_num_rows = nr;
        wq_addr.delete();
        wq_data.delete();
        done_cnt    = 0;
        stable_viol = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_entry(input logic [15:0] r, input logic [15:0] c, input logic l, output bit ok);
        ok       = 0;
        in_valid = 1'b1;
        in_row   = r;
        in_col   = c;
        in_last  = l;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (in_ready) begin
                ok = 1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (done_cnt > 0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({mem_we, in_ready, busy, done, err} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b expected 00000", {mem_we, in_ready, busy, done, err});
        end
        n_cmp++;
        if (nnz_count !== 32'd0 || mem_addr !== 32'd0 || mem_wdata !== '0) begin
            n_bad++;
            $display("FAIL reset_values: got nnz=%h addr=%h data=%h expected all 0", nnz_count, mem_addr, mem_wdata);
        end
    endtask

    // Scenario with row_ptr={0,2,3}, col_idx={1,3,0}; used with and without stalls.
    task automatic run_basic(input string tag);
        bit          ok;
        bit          all_ok;
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        ea = '{32'h1000, 32'h2000, 32'h2004, 32'h1004, 32'h2008, 32'h1008};
        ed = '{32'd0,    32'd1,    32'd3,    32'd2,    32'd0,    32'd3};
        all_ok = 1;
        start_job(32'h1000, 32'h2000, 16'd2);
        send_entry(16'd0, 16'd1, 1'b0, ok); all_ok &= ok;
        send_entry(16'd0, 16'd3, 1'b0, ok); all_ok &= ok;
        send_entry(16'd1, 16'd0, 1'b1, ok); all_ok &= ok;
        wait_done(ok); all_ok &= ok;
        n_cmp++;
        if (!all_ok) begin
            n_bad++;
            $display("FAIL %s handshake_or_done_timeout: got 0 expected 1", tag);
        end
        n_cmp++;
        if (wq_addr.size() != ea.size()) begin
            n_bad++;
            $display("FAIL %s write_count: got %0d expected %0d", tag, wq_addr.size(), ea.size());
        end
        for (int i = 0; i < ea.size() && i < wq_addr.size(); i++) begin
            n_cmp++;
            if (wq_addr[i] !== ea[i] || wq_data[i] !== ed[i]) begin
                n_bad++;
                $display("FAIL %s write%0d: got %h<=%h expected %h<=%h", tag, i, wq_addr[i], wq_data[i], ea[i], ed[i]);
            end
        end
        n_cmp++;
        if (nnz_count !== 32'd3 || done_cnt != 1 || busy !== 1'b0 || err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s status: got nnz=%0d done_cycles=%0d busy=%b err=%b expected 3 1 0 0",
                     tag, nnz_count, done_cnt, busy, err);
        end
    endtask

    task automatic test_basic();
        stall_n = 0;
        run_basic("basic");
        repeat (5) @(negedge clk);
        n_cmp++;
        if (nnz_count !== 32'd3) begin
            n_bad++;
            $display("FAIL nnz_hold: got %0d expected 3", nnz_count);
        end
    endtask

    task automatic test_stall();
        stall_n = 3;
        run_basic("stall");
        n_cmp++;
        if (stable_viol != 0) begin
            n_bad++;
            $display("FAIL stall_stability: got %0d violations expected 0", stable_viol);
        end
        stall_n = 0;
    endtask

    task automatic test_empty_rows();
        bit          ok;
        bit          ok2;
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        ea = '{32'h0, 32'h4, 32'h8, 32'h100, 32'hC, 32'h10};
        ed = '{32'd0, 32'd0, 32'd0, 32'd5,   32'd1, 32'd1};
        stall_n = 0;
        start_job(32'h0, 32'h100, 16'd4);
        // A start pulse while busy must have no effect.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        send_entry(16'd2, 16'd5, 1'b1, ok);
        wait_done(ok2);
        n_cmp++;
        if (!(ok && ok2)) begin
            n_bad++;
            $display("FAIL empty_rows timeout: got 0 expected 1");
        end
        n_cmp++;
        if (wq_addr.size() != ea.size()) begin
            n_bad++;
            $display("FAIL empty_rows write_count: got %0d expected %0d", wq_addr.size(), ea.size());
        end
        for (int i = 0; i < ea.size() && i < wq_addr.size(); i++) begin
            n_cmp++;
            if (wq_addr[i] !== ea[i] || wq_data[i] !== ed[i]) begin
                n_bad++;
                $display("FAIL empty_rows write%0d: got %h<=%h expected %h<=%h", i, wq_addr[i], wq_data[i], ea[i], ed[i]);
            end
        end
        n_cmp++;
        if (nnz_count !== 32'd1 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL empty_rows status: got nnz=%0d done_cycles=%0d expected 1 1", nnz_count, done_cnt);
        end
    endtask

    task automatic test_zero_rows();
        bit ok;
        stall_n = 0;
        start_job(32'h3000, 32'h4000, 16'd0);
        wait_done(ok);
        n_cmp++;
        if (!ok || wq_addr.size() != 1) begin
            n_bad++;
            $display("FAIL zero_rows write_count: got %0d expected 1", wq_addr.size());
        end else begin
            n_cmp++;
            if (wq_addr[0] !== 32'h3000 || wq_data[0] !== 32'd0) begin
                n_bad++;
                $display("FAIL zero_rows write0: got %h<=%h expected 00003000<=00000000", wq_addr[0], wq_data[0]);
            end
        end
        n_cmp++;
        if (nnz_count !== 32'd0 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL zero_rows status: got nnz=%0d done_cycles=%0d expected 0 1", nnz_count, done_cnt);
        end
    endtask

    task automatic test_wrap();
        bit          ok;
        bit          ok2;
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        ea = '{32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0000_0000};
        ed = '{32'd0,         32'd7,         32'd1};
        stall_n = 0;
        start_job(32'hFFFF_FFFC, 32'hFFFF_FFF8, 16'd1);
        send_entry(16'd0, 16'd7, 1'b1, ok);
        wait_done(ok2);
        n_cmp++;
        if (!(ok && ok2) || wq_addr.size() != ea.size()) begin
            n_bad++;
            $display("FAIL wrap write_count: got %0d expected %0d", wq_addr.size(), ea.size());
        end
        for (int i = 0; i < ea.size() && i < wq_addr.size(); i++) begin
            n_cmp++;
            if (wq_addr[i] !== ea[i] || wq_data[i] !== ed[i]) begin
                n_bad++;
                $display("FAIL wrap write%0d: got %h<=%h expected %h<=%h", i, wq_addr[i], wq_data[i], ea[i], ed[i]);
            end
        end
    endtask

    task automatic test_reset_mid_job();
        bit ok;
        stall_n = 3;
        start_job(32'h1000, 32'h2000, 16'd2);
        send_entry(16'd0, 16'd1, 1'b0, ok);
        send_entry(16'd0, 16'd3, 1'b0, ok);
        n_cmp++;
        if (!ok || mem_we !== 1'b1 || mem_addr !== 32'h2004 || mem_wdata !== 32'd3) begin
            n_bad++;
            $display("FAIL midreset_in_colwr: got we=%b addr=%h data=%h expected 1 00002004 00000003",
                     mem_we, mem_addr, mem_wdata);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({mem_we, in_ready, busy, done, err} !== 5'b0 || nnz_count !== 32'd0 ||
            mem_addr !== 32'd0 || mem_wdata !== '0) begin
            n_bad++;
            $display("FAIL midreset_outputs: got we=%b rdy=%b busy=%b done=%b err=%b nnz=%h addr=%h data=%h expected all 0",
                     mem_we, in_ready, busy, done, err, nnz_count, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        stall_n = 0;
        wq_addr.delete();
        wq_data.delete();
        repeat (6) @(negedge clk);
        n_cmp++;
        if (wq_addr.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_no_resume: got writes=%0d busy=%b expected 0 0", wq_addr.size(), busy);
        end
        run_basic("restart");
    endtask

`ifdef META_ENC_ORDER_CHECK_EN
    task automatic test_order_error();
        bit          ok;
        bit          ok2;
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        ea = '{32'h0, 32'h40, 32'h4, 32'h8};
        ed = '{32'd0, 32'd3,  32'd1, 32'd1};
        stall_n = 0;
        start_job(32'h0, 32'h40, 16'd2);
        send_entry(16'd0, 16'd3, 1'b0, ok);
        send_entry(16'd0, 16'd1, 1'b0, ok2);
        ok &= ok2;
        wait_done(ok2);
        n_cmp++;
        if (!(ok && ok2) || wq_addr.size() != ea.size()) begin
            n_bad++;
            $display("FAIL order_err write_count: got %0d expected %0d", wq_addr.size(), ea.size());
        end
        for (int i = 0; i < ea.size() && i < wq_addr.size(); i++) begin
            n_cmp++;
            if (wq_addr[i] !== ea[i] || wq_data[i] !== ed[i]) begin
                n_bad++;
                $display("FAIL order_err write%0d: got %h<=%h expected %h<=%h", i, wq_addr[i], wq_data[i], ea[i], ed[i]);
            end
        end
        n_cmp++;
        if (err !== 1'b1 || done_cnt != 1 || nnz_count !== 32'd1) begin
            n_bad++;
            $display("FAIL order_err status: got err=%b done_cycles=%0d nnz=%0d expected 1 1 1", err, done_cnt, nnz_count);
        end
    endtask
`else
    task automatic test_lower_row();
        bit          ok;
        bit          ok2;
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        ea = '{32'h0, 32'h4, 32'h40, 32'h44, 32'h8};
        ed = '{32'd0, 32'd0, 32'd4,  32'd2,  32'd2};
        stall_n = 0;
        start_job(32'h0, 32'h40, 16'd2);
        send_entry(16'd1, 16'd4, 1'b0, ok);
        send_entry(16'd0, 16'd2, 1'b1, ok2);
        ok &= ok2;
        wait_done(ok2);
        n_cmp++;
        if (!(ok && ok2) || wq_addr.size() != ea.size()) begin
            n_bad++;
            $display("FAIL lower_row write_count: got %0d expected %0d", wq_addr.size(), ea.size());
        end
        for (int i = 0; i < ea.size() && i < wq_addr.size(); i++) begin
            n_cmp++;
            if (wq_addr[i] !== ea[i] || wq_data[i] !== ed[i]) begin
                n_bad++;
                $display("FAIL lower_row write%0d: got %h<=%h expected %h<=%h", i, wq_addr[i], wq_data[i], ea[i], ed[i]);
            end
        end
        n_cmp++;
        if (err !== 1'b0 || nnz_count !== 32'd2) begin
            n_bad++;
            $display("FAIL lower_row status: got err=%b nnz=%0d expected 0 2", err, nnz_count);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        cfg_row_base = '0;
        cfg_col_base = '0;
        cfg_num_rows = '0;
        in_valid     = 1'b0;
        in_row       = '0;
        in_col       = '0;
        in_last      = 1'b0;
        mem_ready    = 1'b1;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_stall();
        test_empty_rows();
        test_zero_rows();
        test_wrap();
        test_reset_mid_job();
`ifdef META_ENC_ORDER_CHECK_EN
        test_order_error();
`else
        test_lower_row();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bsr_meta_encode.md
BSR_META_ENCODE -- requirements
Module: bsr_meta_encode

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, memory write word width; byte stride per word is DATA_WIDTH/8.
REQ-002 SHALL have clk, input, 1, clock.
REQ-003 SHALL have rst_n, input, 1, reset, asynchronous, active-low.
REQ-004 SHALL have start, input, 1, single-cycle encode request.
REQ-005 SHALL have cfg_row_base, cfg_col_base, input, 32 each, byte base addresses of the row_ptr and col_idx arrays.
REQ-006 SHALL have cfg_num_rows, input, 16, block-row count; sampled on an accepted start.
REQ-007 SHALL have in_valid, in_ready, input/output, 1 each, nonzero-block stream handshake.
REQ-008 SHALL have in_row, in_col, input, 16 each, and in_last, input, 1; together these form the block coordinate and the final-entry flag.
REQ-009 SHALL have mem_we, output, 1; mem_addr, output, 32; mem_wdata, output, DATA_WIDTH; mem_ready, input, 1, write accepted.
REQ-010 SHALL have busy, done, err, outputs, 1 each, and nnz_count, output, 32.

Function
REQ-011 SHALL use FSM states IDLE, ROWPTR, ACCEPT, COLWR, FLUSH, DONE.
REQ-012 In IDLE, start SHALL latch the cfg_* inputs, clear cur_row, nnz and err, and go to ROWPTR; start in any other state SHALL be ignored.
REQ-013 ROWPTR SHALL write row_ptr[cur_row]=nnz to cfg_row_base+cur_row*(DATA_WIDTH/8); on mem_ready it SHALL go to ACCEPT, or to DONE if cfg_num_rows==0.
REQ-014 In ACCEPT, in_ready SHALL be 1 iff in_row==cur_row; a handshake SHALL capture in_col and in_last and go to COLWR.
REQ-015 In ACCEPT, if in_valid is high and in_row>cur_row, in_ready SHALL be 0, cur_row SHALL increment, and the FSM SHALL go to ROWPTR; this emits pointers for empty rows one per row.
REQ-016 COLWR SHALL write col_idx[nnz]=captured col, zero-extended, to cfg_col_base+nnz*(DATA_WIDTH/8); on mem_ready, nnz SHALL increment and the FSM SHALL go to FLUSH if last was captured, else to ACCEPT.
REQ-017 On entry to FLUSH, cur_row SHALL increment; FLUSH SHALL write row_ptr[cur_row]=nnz for each cur_row up to and including cfg_num_rows, one per mem_ready, and then go to DONE.
REQ-018 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE; nnz_count SHALL equal nnz and SHALL hold its value after DONE until the next start.
REQ-020 While mem_we=1 and mem_ready=0, mem_addr and mem_wdata SHALL be held stable; at most one write SHALL be issued per cycle; mem_we SHALL be 1 only in ROWPTR, COLWR and FLUSH.
REQ-021 Address arithmetic SHALL be 32-bit modulo 2^32, and wrap-around SHALL be silent.
REQ-022 A stream with zero nonzeros is unsupported; every job SHALL end with an in_last entry.

Reset
REQ-023 Assertion of rst_n at any time, including mid-job, SHALL force IDLE and clear mem_we, in_ready, busy, done, err and nnz_count to 0, with mem_addr and mem_wdata at 0.
REQ-024 Writes interrupted by reset SHALL NOT be completed after reset release.

Configuration
REQ-025 When META_ENC_ORDER_CHECK_EN is defined, ACCEPT SHALL flag in_row<cur_row, in_row>=cfg_num_rows, or in_col<=previous col in the same row as an error; the offending entry SHALL be consumed and dropped, err SHALL be set sticky, and the FSM SHALL go to FLUSH.
REQ-026 When META_ENC_ORDER_CHECK_EN is undefined, err SHALL be tied to 0, no checks SHALL be made, in_ready SHALL be 1 for in_row<=cur_row, and such entries SHALL be encoded into cur_row.

Verification
REQ-027 Scenario: cfg_num_rows=2, entries (0,1),(0,3),(1,0,last), mem_ready=1 -> row_ptr={0,2,3}, col_idx={1,3,0}, nnz_count=3, one-cycle done.
REQ-028 Scenario: cfg_num_rows=4, entries (2,5,last) -> row_ptr={0,0,0,1,1}, col_idx={5}.
REQ-029 Scenario: mem_ready held low 3 cycles on every write -> mem_addr and mem_wdata stable, and final contents identical to REQ-027.
REQ-030 Scenario: cfg_row_base=0x1000 and cfg_col_base=0x2000 -> row_ptr writes at 0x1000, 0x1004, 0x1008, and col_idx writes at 0x2000, 0x2004, 0x2008 for DATA_WIDTH=32.
REQ-031 Scenario: rst_n pulsed low during COLWR of entry 2 -> all outputs 0 next cycle, then a restart job completes correctly.
REQ-032 Scenario: with META_ENC_ORDER_CHECK_EN, entries (0,3),(0,1) -> err=1, row_ptr={0,1,1} for cfg_num_rows=2, done pulses.
